// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed N-digit 7-segment display driver. A prescaler divides
// clk_osc into digit slots. Each slot selects one digit's anode, and that
// digit's hex value is decoded onto the shared segment bus. A slot-tick
// counter drives a blink phase that can suppress the anodes of individual
// digits. Each digit also has its own decimal point.
//
// Optional feature (compile-time macro):
//   SEG_LEADING_ZERO_BLANK_EN - when defined, leading zero digits are blanked
//   (seg = 0). Digit 0 is never blanked. When undefined, every zero decodes
//   as '0'.
//
// Outputs anode/seg/dp are registered and are computed from the pre-edge
// scan state, so they trail scan_idx by one cycle.
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 65536,
    parameter int BLINK_SLOTS = 512,
    localparam int IDX_W   = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1,
    localparam int PRE_W   = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1,
    localparam int BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1
) (
    input  logic                    clk_osc,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    blink_phase
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0]      pre_q,         pre_d;
    logic [IDX_W-1:0]      scan_idx_q,    scan_idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] anode_q,       anode_d;
    logic [6:0]            seg_q,         seg_d;
    logic                  dp_q,          dp_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                  slot_tick;
    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_dec;
    logic                  digit_blank;

    // Hex-to-segment decode (seg[6]=g ... seg[0]=a). F is shown as blank.
    function automatic logic [6:0] decode_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Unpack the digit bus and build the one-hot-low anode pattern per slot.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = digits[4*gi +: 4];
            assign anode_sel[gi] = (scan_idx_q != IDX_W'(gi));
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // upper_zero[i] is set when digit i and every digit above it are zero.
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] lz_blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign digit_zero[gi] = (digit_val[gi] == 4'h0);
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = digit_zero[gi];
            end else begin : g_chain
                assign upper_zero[gi] = digit_zero[gi] & upper_zero[gi+1];
            end
            // The rightmost digit always shows, so a value of zero stays visible.
            if (gi == 0) begin : g_units
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = upper_zero[gi];
            end
        end
    endgenerate

    assign digit_blank = lz_blank[scan_idx_q];
`else
    assign digit_blank = 1'b0;
`endif

    // A slot ends on the last prescaler count, but only while scanning is enabled.
    assign slot_tick = enable && (pre_q == PRE_LAST);

    assign cur_digit = digit_val[scan_idx_q];
    assign seg_dec   = digit_blank ? 7'b0000000 : decode_hex(cur_digit);

    // Next-state logic for the prescaler, scan index and blink counter.
    always_comb begin
        pre_d         = pre_q;
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        if (slot_tick) begin
            // With a single digit, IDX_LAST is 0 and the index stays at 0.
            if (scan_idx_q == IDX_LAST) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end

            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Output next values are computed from the current (pre-edge) scan state and inputs.
    always_comb begin
        anode_d = '1;
        seg_d   = 7'b0000000;
        dp_d    = 1'b0;

        if (enable) begin
            // A blinking digit loses its anode in the off phase.
            // Segments and dp are still driven while the anode is off.
            if (blink_phase_q && blink_mask[scan_idx_q]) begin
                anode_d = '1;
            end else begin
                anode_d = anode_sel;
            end
            seg_d = seg_dec;
            dp_d  = dp_mask[scan_idx_q];
        end
    end

    // Scan/blink state register; holds its value whenever enable is low.
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            pre_q         <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Registered display outputs; reset leaves the display dark.
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            anode_q <= '1;
            seg_q   <= 7'b0000000;
            dp_q    <= 1'b0;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anode       = anode_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign scan_idx    = scan_idx_q;
    assign blink_phase = blink_phase_q;

endmodule
